// File: rtl/rotl16_serial.sv
// rotl16_serial: serial circular rotator, one bit position per clock.
// The operand A is rotated by B positions (left by default). The result
// is published on C together with a one-cycle DONE pulse.
// Optional feature macro: ROTL_DIR_SEL_EN adds a DIR input.
// DIR=0 selects a left rotation and DIR=1 selects a right rotation.

module rotl16_serial #(
    parameter int WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [WIDTH-1:0]         A,
    input  logic [$clog2(WIDTH)-1:0] B,
`ifdef ROTL_DIR_SEL_EN
    input  logic                     DIR,
`endif
    output logic                     BUSY,
    output logic                     DONE,
    output logic [WIDTH-1:0]         C
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] work_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] step_s;
`ifdef ROTL_DIR_SEL_EN
    logic             dir_r;
`endif

    // Rotate one position toward the MSB; the MSB wraps into bit 0.
    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

`ifdef ROTL_DIR_SEL_EN
    // Rotate one position toward the LSB; bit 0 wraps into the MSB.
    function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction
`endif

    // Next work-register value for a single shift step.
    always_comb begin
        step_s = rotl1(work_r);
`ifdef ROTL_DIR_SEL_EN
        if (dir_r) begin
            step_s = rotr1(work_r);
        end else begin
            step_s = rotl1(work_r);
        end
`endif
    end

    // Control FSM. The work register, the counter and all outputs are registered here.
    // C is written only when the FSM enters DONE, so intermediate rotations stay hidden.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            work_r  <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            C       <= {WIDTH{1'b0}};
            DONE    <= 1'b0;
            BUSY    <= 1'b0;
`ifdef ROTL_DIR_SEL_EN
            dir_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        work_r <= A;
                        cnt_r  <= B;
                        BUSY   <= 1'b1;
`ifdef ROTL_DIR_SEL_EN
                        dir_r  <= DIR;
`endif
                        if (B != CNT_ZERO) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            // A zero rotate amount publishes the operand unchanged.
                            state_r <= ST_DONE;
                            C       <= A;
                            DONE    <= 1'b1;
                        end
                    end else begin
                        BUSY <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work_r <= step_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_DONE;
                        C       <= step_s;
                        DONE    <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    DONE    <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule
